// File: rtl/dec_unbinder_search.sv
// Decoder-side unbinder: right-rotates a bound hypervector by its binding shift,
// then scans the level item memory one level per cycle for the best sparse overlap.
module dec_unbinder_search #(
  parameter int HV_DIM     = 1024,
  parameter int NUM_LEVELS = 10,
  parameter int SHIFT_W    = $clog2(HV_DIM),
  parameter int LVL_W      = $clog2(NUM_LEVELS),
  parameter int CNT_W      = $clog2(HV_DIM + 1)
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start_decoding,
  input  logic [HV_DIM-1:0]  bound_hv,
  input  logic [SHIFT_W-1:0] shift_amt,
  input  logic [HV_DIM-1:0]  level_hv [0:NUM_LEVELS-1],
  output logic [HV_DIM-1:0]  unbound_hv,
  output logic               busy,
  output logic               done,
  output logic [LVL_W-1:0]   best_level,
  output logic [CNT_W-1:0]   best_score
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNBIND,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

  state_t             state, state_nxt;
  logic [LVL_W-1:0]   k;
  logic [LVL_W-1:0]   k_q;
  logic [CNT_W-1:0]   score_q;
  logic               cmp_vld;
  logic [HV_DIM-1:0]  bound_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               accept;

  function automatic logic [HV_DIM-1:0] rotate_right(input logic [HV_DIM-1:0] v,
                                                     input logic [SHIFT_W-1:0] s);
    logic [HV_DIM-1:0] r;
    r = '0;
    // HV_DIM is a power of two, so the modulo reduces to a mask.
    for (int i = 0; i < HV_DIM; i++)
      r[i] = v[(i + int'(s)) & (HV_DIM - 1)];
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [HV_DIM-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < HV_DIM; i++)
      cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  assign accept = (state == S_IDLE) && start_decoding;

  always_ff @(posedge clk) begin
    if (nrst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_decoding) state_nxt = S_UNBIND;
      end
      S_UNBIND: state_nxt = S_SCAN;
      S_SCAN:   if (k == LAST_LEVEL) state_nxt = S_DRAIN;
      S_DRAIN:  state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: pure data capture registers carry no reset; they are only read after an accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      bound_q <= bound_hv;
      shift_q <= shift_amt;
    end
  end

  // The overlap score is registered before the compare, which is why the
  // DRAIN state exists: the last level's compare lands one cycle after SCAN.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (nrst) begin
      k          <= '0;
      k_q        <= '0;
      score_q    <= '0;
      cmp_vld    <= 1'b0;
      unbound_hv <= '0;
      best_level <= '0;
      best_score <= '0;
    end else begin
      cmp_vld <= (state == S_SCAN);
      if (cmp_vld && (score_q > best_score)) begin
        best_score <= score_q;
        best_level <= k_q;
      end
      case (state)
        S_UNBIND: begin
          unbound_hv <= rotate_right(bound_q, shift_q);
          best_level <= '0;
          best_score <= '0;
          k          <= '0;
        end
        S_SCAN: begin
          score_q <= popcount(unbound_hv & level_hv[k]);
          k_q     <= k;
          k       <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_unbinder_search.sv
// Self-checking bench for dec_unbinder_search: a timeline/result model checked every
// cycle, plus directed cases with literal expectations and a randomized soak.
module tb_dec_unbinder_search;

  localparam int N  = 1024;
  localparam int L  = 10;
  localparam int SW = $clog2(N);
  localparam int LW = $clog2(L);
  localparam int CW = $clog2(N + 1);
  localparam int DONE_LAT = 12;
  localparam int OP_SPAN  = 13;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start_decoding;
  logic [N-1:0]  bound_hv;
  logic [SW-1:0] shift_amt;
  logic [N-1:0]  level_hv [0:L-1];
  logic [N-1:0]  unbound_hv;
  logic          busy;
  logic          done;
  logic [LW-1:0] best_level;
  logic [CW-1:0] best_score;

  int checks = 0;
  int errors = 0;

  dec_unbinder_search #(.HV_DIM(N), .NUM_LEVELS(L)) dut (
    .clk(clk), .nrst(nrst), .start_decoding(start_decoding),
    .bound_hv(bound_hv), .shift_amt(shift_amt), .level_hv(level_hv),
    .unbound_hv(unbound_hv), .busy(busy), .done(done),
    .best_level(best_level), .best_score(best_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rand_hv();
    logic [N-1:0] v;
    for (int w = 0; w < N / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Encoder binding: cyclic left rotate.
  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int s);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[(i + s) % N] = v[i];
    return r;
  endfunction

  // ---------------- reference model ----------------
  // m_phase counts cycles since the accepted start edge; -1 means idle.
  int           m_phase = -1;
  bit           armed = 1'b0;
  logic [N-1:0] m_new_unb, m_hold_unb;
  int           m_new_lvl, m_new_score, m_hold_lvl, m_hold_score;

  always @(posedge clk) begin
    if (nrst) begin
      m_phase      = -1;
      m_hold_unb   = '0;
      m_hold_lvl   = 0;
      m_hold_score = 0;
      armed        = 1'b1;
    end else if (m_phase < 0) begin
      if (start_decoding) begin
        m_phase = 0;
        for (int i = 0; i < N; i++) m_new_unb[i] = bound_hv[(i + int'(shift_amt)) % N];
        m_new_lvl   = 0;
        m_new_score = 0;
        for (int j = 0; j < L; j++) begin
          int s;
          s = $countones(m_new_unb & level_hv[j]);
          if (s > m_new_score) begin
            m_new_score = s;
            m_new_lvl   = j;
          end
        end
      end
    end else begin
      m_phase++;
      if (m_phase == DONE_LAT) begin
        m_hold_unb   = m_new_unb;
        m_hold_lvl   = m_new_lvl;
        m_hold_score = m_new_score;
      end
      if (m_phase >= OP_SPAN) m_phase = -1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", busy, m_phase >= 0);
      check("done", done, m_phase == DONE_LAT);
      if (m_phase < 0 || m_phase == DONE_LAT) begin
        check("unbound_diff_bits", $countones(unbound_hv ^ m_hold_unb), 0);
        check("best_level", best_level, m_hold_lvl);
        check("best_score", best_score, m_hold_score);
      end else if (m_phase >= 1) begin
        check("unbound_diff_bits_busy", $countones(unbound_hv ^ m_new_unb), 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic start_op(input logic [N-1:0] hv, input int sh);
    @(negedge clk);
    start_decoding = 1'b1;
    bound_hv       = hv;
    shift_amt      = SW'(sh);
    @(negedge clk);
    start_decoding = 1'b0;
  endtask

  // Called at the first negedge after the start edge; returns cycles until done.
  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, n, DONE_LAT);
  endtask

  initial begin
    logic [N-1:0] v;
    int           sh;
    int           cnt;

    nrst           = 1'b1;
    start_decoding = 1'b0;
    bound_hv       = '0;
    shift_amt      = '0;
    for (int j = 0; j < L; j++) level_hv[j] = rand_hv();
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_score", best_score, 0);
    nrst = 1'b0;

    // Rotated level 6 with shift 37.
    start_op(rotl(level_hv[6], 37), 37);
    wait_done("latency_l6");
    check("l6_level", best_level, 6);
    check("l6_score", best_score, $countones(level_hv[6]));
    check("l6_unbound", $countones(unbound_hv ^ level_hv[6]), 0);

    // Pass-through with shift 0, then wrap with shift 1023.
    start_op(level_hv[0], 0);
    wait_done("latency_s0");
    check("s0_level", best_level, 0);
    check("s0_unbound", $countones(unbound_hv ^ level_hv[0]), 0);
    start_op(rotl(level_hv[0], N - 1), N - 1);
    wait_done("latency_s1023");
    check("s1023_level", best_level, 0);
    check("s1023_unbound", $countones(unbound_hv ^ level_hv[0]), 0);

    // Tie between levels 2 and 5: lowest index wins.
    @(negedge clk);
    level_hv[5] = level_hv[2];
    start_op(level_hv[2], 0);
    wait_done("latency_tie");
    check("tie_level", best_level, 2);
    level_hv[5] = rand_hv();

    // All-zero input.
    start_op('0, 5);
    wait_done("latency_zero");
    check("zero_level", best_level, 0);
    check("zero_score", best_score, 0);

    // Second start while busy is ignored; start during DONE ignored, then accepted.
    start_op(rotl(level_hv[3], 100), 100);
    repeat (2) @(negedge clk);
    start_decoding = 1'b1;
    bound_hv       = level_hv[8];
    shift_amt      = '0;
    @(negedge clk);
    start_decoding = 1'b0;
    begin
      int n;
      n = 3;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("latency_ignore", n, DONE_LAT);
    end
    check("ignore_level", best_level, 3);
    start_decoding = 1'b1;
    bound_hv       = level_hv[9];
    @(negedge clk);
    check("busy_gap", busy, 0);
    @(negedge clk);
    start_decoding = 1'b0;
    check("restart_busy", busy, 1);
    wait_done("latency_restart");
    check("restart_level", best_level, 9);

    // Reset in SCAN at k=4 aborts the search.
    start_op(rotl(level_hv[7], 500), 500);
    repeat (5) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_level", best_level, 0);
    check("abort_score", best_score, 0);
    check("abort_unbound", $countones(unbound_hv), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    start_op(rotl(level_hv[7], 500), 500);
    wait_done("latency_after_abort");
    check("after_abort_level", best_level, 7);

    // Randomized soak: random start pulses, some while busy.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start_decoding = ($urandom_range(0, 4) == 0);
      sh = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0) begin
        v = rand_hv();
      end else begin
        v = rotl(level_hv[$urandom_range(0, L - 1)], sh);
        v = v ^ (rand_hv() & rand_hv() & rand_hv());
      end
      bound_hv  = v;
      shift_amt = SW'(sh);
    end
    @(negedge clk);
    start_decoding = 1'b0;
    repeat (OP_SPAN + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
